// File: rtl/tl_execute.sv
// tl_execute: EX stage of the 5-stage MIPS pipeline.
// Forwards rs/rt operands from EX/MEM and MEM/WB, selects ALU operand B,
// runs the 4-bit-coded ALU, computes the branch target and the destination
// register, and registers everything into the EX/MEM latch on the falling
// clock edge. A stall holds the latch and a flush loads a bubble into it.
module tl_execute #(
  parameter int LEN                  = 32,
  parameter int CANTIDAD_REGISTROS   = 32,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int NB_ALU_CONTROL       = 4,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 3,
  parameter int NB_CTRL_EX           = 7
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [LEN-1:0]                  i_adder_pc,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rs,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd,
  input  logic [4:0]                      i_shamt,
  input  logic [LEN-1:0]                  i_dato1,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic [LEN-1:0]                  i_sign_extend,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
  input  logic                            i_exmem_regwrite,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_exmem_rd,
  input  logic [LEN-1:0]                  i_exmem_result,
  input  logic                            i_memwb_regwrite,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_memwb_rd,
  input  logic [LEN-1:0]                  i_memwb_data,
  input  logic                            i_stall,
  input  logic                            i_flush,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
  output logic [LEN-1:0]                  o_alu_result,
  output logic                            o_zero,
  output logic [LEN-1:0]                  o_dato2,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [LEN-1:0]                  o_branch_target
);

  // Control field positions inside i_ctrl_ex = {RegDst, ALUSrc, Jump, alu_code}.
  localparam int IDX_REGDST = NB_ALU_CONTROL + 2;
  localparam int IDX_ALUSRC = NB_ALU_CONTROL + 1;
  localparam int IDX_JUMP   = NB_ALU_CONTROL;

  // Forwarding mux: the newer EX/MEM result beats MEM/WB; register 0 never forwards.
  function automatic logic [LEN-1:0] fwd_f(
    input logic                            exmem_rw,
    input logic [NB_ADDRESS_REGISTROS-1:0] exmem_rd,
    input logic [LEN-1:0]                  exmem_res,
    input logic                            memwb_rw,
    input logic [NB_ADDRESS_REGISTROS-1:0] memwb_rd,
    input logic [LEN-1:0]                  memwb_dat,
    input logic [NB_ADDRESS_REGISTROS-1:0] src,
    input logic [LEN-1:0]                  rf_dat
  );
    logic [LEN-1:0] r;
    if (exmem_rw && (exmem_rd != '0) && (exmem_rd == src)) begin
      r = exmem_res;
    end else if (memwb_rw && (memwb_rd != '0) && (memwb_rd == src)) begin
      r = memwb_dat;
    end else begin
      r = rf_dat;
    end
    return r;
  endfunction

  // ALU: shifts, add/sub (wrapping), logic ops, compares, LUI and pass-B.
  function automatic logic [LEN-1:0] alu_f(
    input logic [NB_ALU_CONTROL-1:0] code,
    input logic [LEN-1:0]            a,
    input logic [LEN-1:0]            b,
    input logic [4:0]                sh
  );
    logic [LEN-1:0] r;
    case (code)
      4'b0000: r = b << sh;
      4'b0001: r = b >> sh;
      4'b0010: r = $unsigned($signed(b) >>> sh);
      4'b0011: r = b << a[4:0];
      4'b0100: r = b >> a[4:0];
      4'b0101: r = $unsigned($signed(b) >>> a[4:0]);
      4'b0110: r = a + b;
      4'b0111: r = a - b;
      4'b1000: r = a & b;
      4'b1001: r = a | b;
      4'b1010: r = a ^ b;
      4'b1011: r = ~(a | b);
      4'b1100: r = ($signed(a) < $signed(b)) ? LEN'(1) : LEN'(0);
      4'b1101: r = b << 5'd16;
      4'b1110: r = (a < b) ? LEN'(1) : LEN'(0);
      4'b1111: r = b;
      default: r = b;
    endcase
    return r;
  endfunction

  logic [LEN-1:0] fwd_a_s;
  logic [LEN-1:0] fwd_b_s;
  logic [LEN-1:0] op_b_s;
  logic [LEN-1:0] alu_s;
  logic           unused_jump_s;

  logic [NB_CTRL_WB-1:0]           ctrl_wb_d,  ctrl_wb_q;
  logic [NB_CTRL_MEM-1:0]          ctrl_mem_d, ctrl_mem_q;
  logic [LEN-1:0]                  alu_d,      alu_q;
  logic                            zero_d,     zero_q;
  logic [LEN-1:0]                  dato2_d,    dato2_q;
  logic [NB_ADDRESS_REGISTROS-1:0] wreg_d,     wreg_q;
  logic [LEN-1:0]                  bt_d,       bt_q;

  // Jump is resolved earlier in the pipeline; EX only carries the bit.
  assign unused_jump_s = i_ctrl_ex[IDX_JUMP];

  // Operand forwarding, operand B selection and the ALU itself.
  always_comb begin
    fwd_a_s = fwd_f(i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                    i_memwb_regwrite, i_memwb_rd, i_memwb_data, i_rs, i_dato1);
    fwd_b_s = fwd_f(i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                    i_memwb_regwrite, i_memwb_rd, i_memwb_data, i_rt, i_dato2);
    if (i_ctrl_ex[IDX_ALUSRC]) begin
      op_b_s = i_sign_extend;
    end else begin
      op_b_s = fwd_b_s;
    end
    alu_s = alu_f(i_ctrl_ex[NB_ALU_CONTROL-1:0], fwd_a_s, op_b_s, i_shamt);
  end

  // EX/MEM next state: flush beats stall, stall holds, otherwise load.
  always_comb begin
    ctrl_wb_d  = ctrl_wb_q;
    ctrl_mem_d = ctrl_mem_q;
    alu_d      = alu_q;
    zero_d     = zero_q;
    dato2_d    = dato2_q;
    wreg_d     = wreg_q;
    bt_d       = bt_q;
    if (i_flush) begin
      ctrl_wb_d  = '0;
      ctrl_mem_d = '0;
      alu_d      = '0;
      zero_d     = 1'b0;
      dato2_d    = '0;
      wreg_d     = '0;
      bt_d       = '0;
    end else if (!i_stall) begin
      ctrl_wb_d  = i_ctrl_wb;
      ctrl_mem_d = i_ctrl_mem;
      alu_d      = alu_s;
      zero_d     = (alu_s == '0);
      dato2_d    = fwd_b_s;
      wreg_d     = i_ctrl_ex[IDX_REGDST] ? i_rd : i_rt;
      bt_d       = i_adder_pc + (i_sign_extend << 2'd2);
    end else begin
      ctrl_wb_d  = ctrl_wb_q;
    end
  end

  // EX/MEM latch, clocked on the falling edge with asynchronous clear.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_wb_q  <= '0;
      ctrl_mem_q <= '0;
      alu_q      <= '0;
      zero_q     <= 1'b0;
      dato2_q    <= '0;
      wreg_q     <= '0;
      bt_q       <= '0;
    end else begin
      ctrl_wb_q  <= ctrl_wb_d;
      ctrl_mem_q <= ctrl_mem_d;
      alu_q      <= alu_d;
      zero_q     <= zero_d;
      dato2_q    <= dato2_d;
      wreg_q     <= wreg_d;
      bt_q       <= bt_d;
    end
  end

  assign o_ctrl_wb       = ctrl_wb_q;
  assign o_ctrl_mem      = ctrl_mem_q;
  assign o_alu_result    = alu_q;
  assign o_zero          = zero_q;
  assign o_dato2         = dato2_q;
  assign o_write_reg     = wreg_q;
  assign o_branch_target = bt_q;

endmodule

// File: tb/tb_tl_execute.sv
// Scoreboard bench for tl_execute: expected EX/MEM contents are pushed when
// stimulus is driven and popped/compared on the rising edge after the DUT's
// falling-edge update.
module tb_tl_execute;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] d2;
    logic [4:0]  wr;
    logic [31:0] bt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] adder_pc, dato1, dato2, sign_ext, exmem_result, memwb_data;
  logic [4:0]  rs, rt, rd, shamt, exmem_rd, memwb_rd;
  logic [1:0]  ctrl_wb;
  logic [2:0]  ctrl_mem;
  logic [6:0]  ctrl_ex;
  logic        exmem_rw, memwb_rw, stall, flush;
  logic [1:0]  o_ctrl_wb;
  logic [2:0]  o_ctrl_mem;
  logic [31:0] o_alu_result, o_dato2, o_branch_target;
  logic        o_zero;
  logic [4:0]  o_write_reg;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_total = 0;
  int   n_bad   = 0;

  tl_execute dut (
    .i_clk(clk), .i_rst(rst), .i_adder_pc(adder_pc),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt),
    .i_dato1(dato1), .i_dato2(dato2), .i_sign_extend(sign_ext),
    .i_ctrl_wb(ctrl_wb), .i_ctrl_mem(ctrl_mem), .i_ctrl_ex(ctrl_ex),
    .i_exmem_regwrite(exmem_rw), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_regwrite(memwb_rw), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
    .i_stall(stall), .i_flush(flush),
    .o_ctrl_wb(o_ctrl_wb), .o_ctrl_mem(o_ctrl_mem), .o_alu_result(o_alu_result),
    .o_zero(o_zero), .o_dato2(o_dato2), .o_write_reg(o_write_reg),
    .o_branch_target(o_branch_target)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t s;
    s = {o_ctrl_wb, o_ctrl_mem, o_alu_result, o_zero, o_dato2, o_write_reg, o_branch_target};
    return s;
  endfunction

  // Reference model of one load, written from the instruction definitions.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] a, bf, b, r, sext;
    int          sa;
    if (exmem_rw && exmem_rd != 5'd0 && exmem_rd == rs) a = exmem_result;
    else if (memwb_rw && memwb_rd != 5'd0 && memwb_rd == rs) a = memwb_data;
    else a = dato1;
    if (exmem_rw && exmem_rd != 5'd0 && exmem_rd == rt) bf = exmem_result;
    else if (memwb_rw && memwb_rd != 5'd0 && memwb_rd == rt) bf = memwb_data;
    else bf = dato2;
    b  = ctrl_ex[5] ? sign_ext : bf;
    sa = (ctrl_ex[3:0] >= 4'd3 && ctrl_ex[3:0] <= 4'd5) ? int'(a[4:0]) : int'(shamt);
    sext = b[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0;
    case (ctrl_ex[3:0])
      4'd0, 4'd3: r = b << sa;
      4'd1, 4'd4: r = b >> sa;
      4'd2, 4'd5: r = (b >> sa) | sext;
      4'd6:  r = a + b;
      4'd7:  r = a + ~b + 32'd1;
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~a & ~b;
      4'd12: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd13: r = {b[15:0], 16'h0000};
      4'd14: r = {31'd0, (a < b)};
      default: r = b;
    endcase
    e.wb = ctrl_wb; e.mem = ctrl_mem; e.alu = r; e.zero = (r == 32'd0);
    e.d2 = bf; e.wr = ctrl_ex[6] ? rd : rt;
    e.bt = adder_pc + {sign_ext[29:0], 2'b00};
    return e;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [4:0] i_rs, input logic [4:0] i_rt,
                       input logic [4:0] i_rd, input logic [4:0] sh, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] se, input logic [1:0] wb,
                       input logic [2:0] mem, input logic [6:0] ex);
    adder_pc = pc; rs = i_rs; rt = i_rt; rd = i_rd; shamt = sh; dato1 = d1;
    dato2 = d2; sign_ext = se; ctrl_wb = wb; ctrl_mem = mem; ctrl_ex = ex;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mdat);
    exmem_rw = erw; exmem_rd = erd; exmem_result = eres;
    memwb_rw = mrw; memwb_rd = mrd; memwb_data = mdat;
  endtask

  task automatic test_reset();
    exp_t got;
    #1;
    got = sample();
    n_total++;
    if (got !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_init: got=%h exp=0", got);
    end
    repeat (2) @(posedge clk);
    got = sample();
    n_total++;
    if (got !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_held: got=%h exp=0", got);
    end
    rst = 1'b1;
    last_exp = exp_t'(0);
  endtask

  task automatic test_add();
    exp_t e, got;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(32'h100, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5, 32'd7, 32'd4, 2'b10, 3'b000, 7'b100_0110);
    sb_q.push_back('{wb: 2'b10, mem: 3'b000, alu: 32'd12, zero: 1'b0, d2: 32'd7, wr: 5'd3, bt: 32'h110});
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL add: got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_forward();
    exp_t e, got;
    set_fwd(1'b1, 5'd1, 32'd9, 1'b1, 5'd1, 32'd4);
    drive(32'h0, 5'd1, 5'd2, 5'd0, 5'd0, 32'd0, 32'd9, 32'd0, 2'b11, 3'b100, 7'b000_0111);
    sb_q.push_back('{wb: 2'b11, mem: 3'b100, alu: 32'd0, zero: 1'b1, d2: 32'd9, wr: 5'd2, bt: 32'h0});
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL fwd_exmem_wins: got=%h exp=%h", got, e);
    end
    // MEM/WB-only forwarding on rt, used as store data and operand B.
    set_fwd(1'b1, 5'd7, 32'd111, 1'b1, 5'd2, 32'd40);
    drive(32'h20, 5'd1, 5'd2, 5'd4, 5'd0, 32'd2, 32'd99, 32'd1, 2'b00, 3'b001, 7'b000_0110);
    sb_q.push_back('{wb: 2'b00, mem: 3'b001, alu: 32'd42, zero: 1'b0, d2: 32'd40, wr: 5'd2, bt: 32'h24});
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL fwd_memwb: got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    logic [31:0] want [3];
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    want[0] = 32'hF800_0000; want[1] = 32'd1; want[2] = 32'd0;
    drive(32'h0, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 2'b10, 3'b000, 7'b100_0010);
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{wb: 2'b10, mem: 3'b000, alu: want[k], zero: (want[k] == 32'd0),
                       d2: dato2, wr: 5'd3, bt: 32'h0});
      @(negedge clk); @(posedge clk);
      got = sample(); e = sb_q.pop_front(); last_exp = e;
      n_total++;
      if (got !== e) begin
        n_bad++; $display("FAIL b2b_%0d (sra/slt/sltu): got=%h exp=%h", k, got, e);
      end
      dato1 = 32'hFFFF_FFFF; dato2 = 32'd1;
      ctrl_ex = (k == 0) ? 7'b100_1100 : 7'b100_1110;
    end
  endtask

  task automatic test_imm();
    exp_t e, got;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(32'h10, 5'd1, 5'd2, 5'd3, 5'd0, 32'h20, 32'h55, 32'hFFFF_FFFC, 2'b01, 3'b010, 7'b010_0110);
    sb_q.push_back('{wb: 2'b01, mem: 3'b010, alu: 32'h1C, zero: 1'b0, d2: 32'h55, wr: 5'd2, bt: 32'h0});
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL imm_branch: got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_alu_sweep();
    exp_t e, got;
    for (int n = 0; n < 48; n++) begin
      set_fwd($urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)), $urandom,
              $urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)), $urandom);
      drive($urandom, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 5'($urandom),
            5'($urandom), (n % 5 == 0) ? 32'd0 : $urandom, (n % 3 == 0) ? 32'h8000_0000 : $urandom,
            $urandom, 2'($urandom), 3'($urandom), {3'($urandom), 4'(n % 16)});
      sb_q.push_back(model());
      @(negedge clk); @(posedge clk);
      got = sample(); e = sb_q.pop_front(); last_exp = e;
      n_total++;
      if (got !== e) begin
        n_bad++; $display("FAIL alu_code_%0d: got=%h exp=%h", n % 16, got, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    exp_t e, got;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(32'h40, 5'd5, 5'd6, 5'd7, 5'd0, 32'd3, 32'd10, 32'd2, 2'b11, 3'b111, 7'b100_1001);
    sb_q.push_back(model());
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL pre_stall: got=%h exp=%h", got, e);
    end
    stall = 1'b1;
    drive(32'h80, 5'd8, 5'd9, 5'd10, 5'd1, 32'd100, 32'd200, 32'd8, 2'b01, 3'b011, 7'b000_0110);
    sb_q.push_back(last_exp);
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front();
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL stall_hold: got=%h exp=%h", got, e);
    end
    flush = 1'b1;
    sb_q.push_back(exp_t'(0));
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL stall_flush: got=%h exp=%h", got, e);
    end
    stall = 1'b0; flush = 1'b0;
    set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    drive(32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h11, 32'h22, 32'h0, 2'b10, 3'b000, 7'b000_0110);
    sb_q.push_back('{wb: 2'b10, mem: 3'b000, alu: 32'h33, zero: 1'b0, d2: 32'h22, wr: 5'd0, bt: 32'h0});
    @(negedge clk); @(posedge clk);
    got = sample(); e = sb_q.pop_front(); last_exp = e;
    n_total++;
    if (got !== e) begin
      n_bad++; $display("FAIL r0_no_fwd: got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_reset_midop();
    exp_t got;
    #2 rst = 1'b0;
    #1;
    got = sample();
    n_total++;
    if (got !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_async: got=%h exp=0", got);
    end
    @(negedge clk); @(posedge clk);
    got = sample();
    n_total++;
    if (got !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_hold_edge: got=%h exp=0", got);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(32'h4, 5'd1, 5'd2, 5'd3, 5'd1, 32'd1, 32'd2, 32'd3, 2'b11, 3'b111, 7'b100_0110);
    test_reset();
    test_add();
    test_forward();
    test_back_to_back();
    test_imm();
    test_alu_sweep();
    test_stall_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
